// File: rtl/axil_bus_pkg.sv
// Types and constants shared by the AXI4-Lite to simple-bus bridge.
// Holds the FSM state encoding and the AXI response codes.
package axil_bus_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ISSUE = 3'd1,
    WR_RESP  = 3'd2,
    RD_ISSUE = 3'd3,
    RD_WAIT  = 3'd4,
    RD_RESP  = 3'd5
  } axil_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_to_bus.sv
// AXI4-Lite slave to single-outstanding word bus bridge; AW/W/AR captured in IDLE, one transaction at a time.
// Latency: AW+W to B is 2 cycles, AR to R is 2 cycles plus bus read latency; stalls on m_ready/m_rvalid/s_bready/s_rready.
// Optional AXIL2BUS_STRB_CHECK_EN: writes with partial strobes over the data width get SLVERR and no bus request.
module axi_lite_to_bus
  import axil_bus_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 24,
  parameter int MASTER_ID_WIDTH = 8,
  parameter int MASTER_ID       = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [31:0]                s_awaddr_i,
  input  logic                       s_awvalid_i,
  output logic                       s_awready_o,
  input  logic [31:0]                s_wdata_i,
  input  logic [3:0]                 s_wstrb_i,
  input  logic                       s_wvalid_i,
  output logic                       s_wready_o,
  output logic [1:0]                 s_bresp_o,
  output logic                       s_bvalid_o,
  input  logic                       s_bready_i,
  input  logic [31:0]                s_araddr_i,
  input  logic                       s_arvalid_i,
  output logic                       s_arready_o,
  output logic [31:0]                s_rdata_o,
  output logic [1:0]                 s_rresp_o,
  output logic                       s_rvalid_o,
  input  logic                       s_rready_i,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic                       m_write_o,
  output logic [ADDRESS_WIDTH-1:0]   m_addr_o,
  output logic [DATA_WIDTH-1:0]      m_data_o,
  output logic [MASTER_ID_WIDTH-1:0] m_id_o,
  input  logic                       m_rvalid_i,
  output logic                       m_rready_o,
  input  logic [DATA_WIDTH-1:0]      m_rdata_i
);

  axil_state_e state_q, state_d;

  logic                     aw_held_q, aw_held_d;
  logic                     w_held_q, w_held_d;
  logic                     ar_held_q, ar_held_d;
  logic [ADDRESS_WIDTH-1:0] awaddr_q, araddr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic                     last_was_read_q;
  logic [ADDRESS_WIDTH-1:0] m_addr_q;
  logic [DATA_WIDTH-1:0]    m_data_q;

  logic aw_fire, w_fire, ar_fire;
  logic wr_avail, rd_avail, conflict, pick_rd, pick_wr, strb_ok;
  logic [ADDRESS_WIDTH-1:0] aw_word, ar_word, aw_eff, ar_eff;
  logic [DATA_WIDTH-1:0]    wdata_eff;

  // Zero-extend before slicing so any ADDRESS_WIDTH can take bits [AW+1:2].
  logic [ADDRESS_WIDTH+33:0] aw_ext, ar_ext;
  assign aw_ext  = {{(ADDRESS_WIDTH+2){1'b0}}, s_awaddr_i};
  assign ar_ext  = {{(ADDRESS_WIDTH+2){1'b0}}, s_araddr_i};
  assign aw_word = aw_ext[ADDRESS_WIDTH+1:2];
  assign ar_word = ar_ext[ADDRESS_WIDTH+1:2];

  logic unused_bits;
  assign unused_bits = ^{aw_ext, ar_ext, s_wdata_i, s_wstrb_i};

`ifdef AXIL2BUS_STRB_CHECK_EN
  localparam logic [3:0] STRB_MASK = 4'((1 << ((DATA_WIDTH + 7) / 8)) - 1);
  logic [3:0] wstrb_q;
  logic [3:0] wstrb_eff;
  assign wstrb_eff = w_held_q ? wstrb_q : s_wstrb_i;
  assign strb_ok   = &(wstrb_eff | ~STRB_MASK);
`else
  assign strb_ok = 1'b1;
`endif

  always_comb begin
    aw_fire   = s_awvalid_i && s_awready_o;
    w_fire    = s_wvalid_i  && s_wready_o;
    ar_fire   = s_arvalid_i && s_arready_o;
    aw_eff    = aw_held_q ? awaddr_q : aw_word;
    ar_eff    = ar_held_q ? araddr_q : ar_word;
    wdata_eff = w_held_q ? wdata_q : s_wdata_i[DATA_WIDTH-1:0];
    wr_avail  = (state_q == IDLE) && (aw_held_q || aw_fire) && (w_held_q || w_fire);
    rd_avail  = (state_q == IDLE) && (ar_held_q || ar_fire);
    conflict  = wr_avail && rd_avail;
    pick_rd   = rd_avail && (!wr_avail || !last_was_read_q);
    pick_wr   = wr_avail && !pick_rd;

    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pick_rd)      state_d = RD_ISSUE;
        else if (pick_wr) state_d = strb_ok ? WR_ISSUE : WR_RESP;
      end
      WR_ISSUE: if (m_ready_i)  state_d = WR_RESP;
      WR_RESP:  if (s_bready_i) state_d = IDLE;
      RD_ISSUE: if (m_ready_i)  state_d = RD_WAIT;
      RD_WAIT:  if (m_rvalid_i) state_d = RD_RESP;
      RD_RESP:  if (s_rready_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    // A write stays held through its B response; a losing write or read just waits here.
    aw_held_d = aw_held_q || aw_fire;
    w_held_d  = w_held_q || w_fire;
    if (state_q == WR_RESP && s_bready_i) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
    ar_held_d = (ar_held_q || ar_fire) && !pick_rd;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      aw_held_q       <= 1'b0;
      w_held_q        <= 1'b0;
      ar_held_q       <= 1'b0;
      awaddr_q        <= '0;
      araddr_q        <= '0;
      wdata_q         <= '0;
      last_was_read_q <= 1'b0;
      m_addr_q        <= '0;
      m_data_q        <= '0;
      s_awready_o     <= 1'b0;
      s_wready_o      <= 1'b0;
      s_arready_o     <= 1'b0;
      m_valid_o       <= 1'b0;
      m_write_o       <= 1'b0;
      m_rready_o      <= 1'b0;
      s_bvalid_o      <= 1'b0;
      s_bresp_o       <= RESP_OKAY;
      s_rvalid_o      <= 1'b0;
      s_rdata_o       <= '0;
`ifdef AXIL2BUS_STRB_CHECK_EN
      wstrb_q         <= '0;
`endif
    end else begin
      state_q   <= state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      ar_held_q <= ar_held_d;
      if (aw_fire) awaddr_q <= aw_word;
      if (ar_fire) araddr_q <= ar_word;
      if (w_fire) begin
        wdata_q <= s_wdata_i[DATA_WIDTH-1:0];
`ifdef AXIL2BUS_STRB_CHECK_EN
        wstrb_q <= s_wstrb_i;
`endif
      end

      // Round-robin only when both directions compete in the same cycle.
      if (conflict) last_was_read_q <= pick_rd;

      if (pick_rd) begin
        m_addr_q <= ar_eff;
      end else if (pick_wr) begin
        m_addr_q  <= aw_eff;
        m_data_q  <= wdata_eff;
        s_bresp_o <= strb_ok ? RESP_OKAY : RESP_SLVERR;
      end

      if (state_q == RD_WAIT && m_rvalid_i) s_rdata_o <= 32'(m_rdata_i);

      s_awready_o <= (state_d == IDLE) && !aw_held_d;
      s_wready_o  <= (state_d == IDLE) && !w_held_d;
      s_arready_o <= (state_d == IDLE) && !ar_held_d;
      m_valid_o   <= (state_d == WR_ISSUE) || (state_d == RD_ISSUE);
      m_write_o   <= (state_d == WR_ISSUE);
      m_rready_o  <= (state_d == RD_WAIT);
      s_bvalid_o  <= (state_d == WR_RESP);
      s_rvalid_o  <= (state_d == RD_RESP);
    end
  end

  assign m_addr_o  = m_addr_q;
  assign m_data_o  = m_data_q;
  assign m_id_o    = MASTER_ID_WIDTH'(MASTER_ID);
  assign s_rresp_o = RESP_OKAY;

endmodule

// File: tb/tb_axi_lite_to_bus.sv
// Scoreboard bench for axi_lite_to_bus: directed AXI-Lite traffic, expected bus requests and responses queued,
// independent monitors compare on each handshake.
module tb_axi_lite_to_bus;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [23:0] data;
  } bus_exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_awaddr = '0;
  logic        s_awvalid = 1'b0;
  logic        s_awready;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready = 1'b1;
  logic [31:0] s_araddr = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready = 1'b1;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_write;
  logic [31:0] m_addr;
  logic [23:0] m_data;
  logic [7:0]  m_id;
  logic        m_rvalid = 1'b0;
  logic        m_rready;
  logic [23:0] m_rdata = '0;

  int checks = 0;
  int failures = 0;
  int bus_seen = 0;
  int b_seen = 0;
  int r_seen = 0;
  int rd_lat = 0;
  logic [23:0] rd_value = '0;

  bus_exp_t    bus_q[$];
  logic [1:0]  b_q[$];
  logic [31:0] r_q[$];

  axi_lite_to_bus #(
    .ADDRESS_WIDTH(32), .DATA_WIDTH(24), .MASTER_ID_WIDTH(8), .MASTER_ID(1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_awaddr_i(s_awaddr), .s_awvalid_i(s_awvalid), .s_awready_o(s_awready),
    .s_wdata_i(s_wdata), .s_wstrb_i(s_wstrb), .s_wvalid_i(s_wvalid), .s_wready_o(s_wready),
    .s_bresp_o(s_bresp), .s_bvalid_o(s_bvalid), .s_bready_i(s_bready),
    .s_araddr_i(s_araddr), .s_arvalid_i(s_arvalid), .s_arready_o(s_arready),
    .s_rdata_o(s_rdata), .s_rresp_o(s_rresp), .s_rvalid_o(s_rvalid), .s_rready_i(s_rready),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_write_o(m_write),
    .m_addr_o(m_addr), .m_data_o(m_data), .m_id_o(m_id),
    .m_rvalid_i(m_rvalid), .m_rready_o(m_rready), .m_rdata_i(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  // Bus request monitor: every accepted request must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      bus_seen++;
      if (bus_q.size() == 0) begin
        chk("bus_unexpected", 32'(m_write), 32'hFFFF_FFFF);
      end else begin
        bus_exp_t e;
        e = bus_q.pop_front();
        chk("bus_write", 32'(m_write), 32'(e.wr));
        chk("bus_addr", m_addr, e.addr);
        chk("bus_id", 32'(m_id), 32'h1);
        if (e.wr) chk("bus_data", 32'(m_data), 32'(e.data));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && s_bvalid && s_bready) begin
      b_seen++;
      if (b_q.size() == 0) chk("b_unexpected", 32'(s_bresp), 32'hFFFF_FFFF);
      else                 chk("bresp", 32'(s_bresp), 32'(b_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (rst_n && s_rvalid && s_rready) begin
      r_seen++;
      chk("rresp", 32'(s_rresp), 32'h0);
      if (r_q.size() == 0) chk("r_unexpected", s_rdata, 32'hFFFF_FFFF);
      else                 chk("rdata", s_rdata, r_q.pop_front());
    end
  end

  // Bus slave: answers each accepted read after rd_lat further cycles.
  initial begin
    int  rd_cnt;
    logic rd_hs, rv_hs;
    rd_cnt = 0;
    forever begin
      @(negedge clk);
      rd_hs = m_valid && m_ready && !m_write;
      rv_hs = m_rvalid && m_rready;
      @(posedge clk); #1;
      if (!rst_n) begin
        rd_cnt = 0;
        m_rvalid = 1'b0;
      end else begin
        if (rv_hs) m_rvalid = 1'b0;
        if (rd_cnt > 0) begin
          rd_cnt--;
          if (rd_cnt == 0) begin m_rvalid = 1'b1; m_rdata = rd_value; end
        end
        if (rd_hs) begin
          if (rd_lat == 0) begin m_rvalid = 1'b1; m_rdata = rd_value; end
          else rd_cnt = rd_lat;
        end
      end
    end
  end

  task automatic send_aw(input logic [31:0] a);
    bit done = 0;
    s_awaddr = a; s_awvalid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (s_awready) begin @(posedge clk); #1; s_awvalid = 1'b0; done = 1; end
    end
    if (!done) begin s_awvalid = 1'b0; timeout("aw_handshake"); end
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    bit done = 0;
    s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (s_wready) begin @(posedge clk); #1; s_wvalid = 1'b0; done = 1; end
    end
    if (!done) begin s_wvalid = 1'b0; timeout("w_handshake"); end
  endtask

  task automatic send_ar(input logic [31:0] a);
    bit done = 0;
    s_araddr = a; s_arvalid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (s_arready) begin @(posedge clk); #1; s_arvalid = 1'b0; done = 1; end
    end
    if (!done) begin s_arvalid = 1'b0; timeout("ar_handshake"); end
  endtask

  task automatic wait_b(input int n);
    int i = 0;
    while (b_seen < n && i < 300) begin @(posedge clk); i++; end
    #1;
    if (b_seen < n) timeout("b_response");
  endtask

  task automatic wait_r(input int n);
    int i = 0;
    while (r_seen < n && i < 300) begin @(posedge clk); i++; end
    #1;
    if (r_seen < n) timeout("r_response");
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_awready"}, 32'(s_awready), 0);
    chk({tag, "_wready"},  32'(s_wready), 0);
    chk({tag, "_arready"}, 32'(s_arready), 0);
    chk({tag, "_m_valid"}, 32'(m_valid), 0);
    chk({tag, "_m_rready"}, 32'(m_rready), 0);
    chk({tag, "_bvalid"},  32'(s_bvalid), 0);
    chk({tag, "_rvalid"},  32'(s_rvalid), 0);
    chk({tag, "_bresp"},   32'(s_bresp), 0);
    chk({tag, "_rdata"},   s_rdata, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int cnt0;
    int k;
    bit seen;

    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_awready", 32'(s_awready), 1);
    chk("post_reset_wready", 32'(s_wready), 1);
    chk("post_reset_arready", 32'(s_arready), 1);
    chk("m_id", 32'(m_id), 32'h1);
    @(posedge clk); #1;

    // AW one cycle before W.
    bus_q.push_back('{wr: 1'b1, addr: 32'h4, data: 24'hABCDEF});
    b_q.push_back(2'b00);
    fork
      send_aw(32'h0000_0010);
      begin @(posedge clk); #1; send_w(32'h00AB_CDEF, 4'hF); end
    join
    wait_b(1);

    // W before AW, bus stalled for 5 cycles; low address bits and upper data bits ignored.
    cnt0 = bus_seen;
    m_ready = 1'b0;
    bus_q.push_back('{wr: 1'b1, addr: 32'h41, data: 24'h123456});
    b_q.push_back(2'b00);
    fork
      send_w(32'hFF12_3456, 4'hF);
      begin repeat (2) @(posedge clk); #1; send_aw(32'h0000_0107); end
    join
    seen = 0;
    for (k = 0; k < 20 && !seen; k++) begin @(negedge clk); seen = m_valid; end
    chk("stall_m_valid_seen", 32'(seen), 1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_m_valid", 32'(m_valid), 1);
      chk("stall_m_write", 32'(m_write), 1);
      chk("stall_m_addr", m_addr, 32'h41);
      chk("stall_m_data", 32'(m_data), 32'h123456);
      @(negedge clk);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_b(2);
    chk("single_bus_request", 32'(bus_seen - cnt0), 1);

    // Read with 3-cycle bus latency, R channel stalled 4 cycles.
    rd_lat = 3; rd_value = 24'h123456;
    s_rready = 1'b0;
    bus_q.push_back('{wr: 1'b0, addr: 32'h2, data: 24'h0});
    r_q.push_back(32'h0012_3456);
    send_ar(32'h0000_0008);
    seen = 0;
    for (k = 0; k < 30 && !seen; k++) begin @(negedge clk); seen = s_rvalid; end
    chk("rd_rvalid_seen", 32'(seen), 1);
    for (int i = 0; i < 4; i++) begin
      chk("rd_hold_rvalid", 32'(s_rvalid), 1);
      chk("rd_hold_rdata", s_rdata, 32'h0012_3456);
      chk("rd_resp_m_rready", 32'(m_rready), 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    s_rready = 1'b1;
    wait_r(1);

    // Simultaneous AR and complete write: read first after reset, write first on the repeat.
    do_reset();
    rd_lat = 1; rd_value = 24'h0A0B0C;
    bus_q.push_back('{wr: 1'b0, addr: 32'h10, data: 24'h0});
    bus_q.push_back('{wr: 1'b1, addr: 32'h20, data: 24'h111111});
    r_q.push_back(32'h000A_0B0C);
    b_q.push_back(2'b00);
    fork
      send_aw(32'h0000_0080);
      send_w(32'h0011_1111, 4'hF);
      send_ar(32'h0000_0040);
    join
    wait_r(2);
    wait_b(3);
    rd_value = 24'h0D0E0F;
    bus_q.push_back('{wr: 1'b1, addr: 32'h21, data: 24'h222222});
    bus_q.push_back('{wr: 1'b0, addr: 32'h11, data: 24'h0});
    r_q.push_back(32'h000D_0E0F);
    b_q.push_back(2'b00);
    fork
      send_aw(32'h0000_0084);
      send_w(32'h0022_2222, 4'hF);
      send_ar(32'h0000_0044);
    join
    wait_b(4);
    wait_r(3);
    chk("arb_queue_drained", 32'(bus_q.size()), 0);

    // Partial strobe.
    cnt0 = bus_seen;
`ifdef AXIL2BUS_STRB_CHECK_EN
    b_q.push_back(2'b10);
`else
    bus_q.push_back('{wr: 1'b1, addr: 32'h8, data: 24'h000055});
    b_q.push_back(2'b00);
`endif
    fork
      send_aw(32'h0000_0020);
      send_w(32'h0000_0055, 4'h1);
    join
    wait_b(5);
`ifdef AXIL2BUS_STRB_CHECK_EN
    chk("strb_bus_requests", 32'(bus_seen - cnt0), 0);
`else
    chk("strb_bus_requests", 32'(bus_seen - cnt0), 1);
`endif

    // Reset while waiting on the bus read response.
    rd_lat = 40; rd_value = 24'h777777;
    bus_q.push_back('{wr: 1'b0, addr: 32'h5, data: 24'h0});
    send_ar(32'h0000_0014);
    seen = 0;
    for (k = 0; k < 20 && !seen; k++) begin @(negedge clk); seen = m_rready; end
    chk("rdwait_m_rready_seen", 32'(seen), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rerelease_arready", 32'(s_arready), 1);
    @(posedge clk); #1;
    rd_lat = 1; rd_value = 24'hABCDE0;
    bus_q.push_back('{wr: 1'b0, addr: 32'hC, data: 24'h0});
    r_q.push_back(32'h00AB_CDE0);
    send_ar(32'h0000_0030);
    wait_r(4);

    repeat (5) @(posedge clk);
    chk("final_bus_q_empty", 32'(bus_q.size()), 0);
    chk("final_b_q_empty", 32'(b_q.size()), 0);
    chk("final_r_q_empty", 32'(r_q.size()), 0);
    chk("final_b_count", 32'(b_seen), 5);
    chk("final_r_count", 32'(r_seen), 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/axi_lite_to_bus.md
AXI_LITE_TO_BUS -- requirements
Module: axi_lite_to_bus

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 32, giving the bus word-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 24, giving the bus data width (at most 32).
REQ-003 The block SHALL have parameter MASTER_ID_WIDTH, default 8, giving the bus master-ID width.
REQ-004 The block SHALL have parameter MASTER_ID, default 1, giving the ID driven on every bus request.
REQ-005 clock  in  1  sole clock; all logic on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 s_awaddr/s_awvalid/s_awready  in/in/out  32/1/1  AXI4-Lite write-address channel.
REQ-008 s_wdata/s_wstrb/s_wvalid/s_wready  in/in/in/out  32/4/1/1  AXI4-Lite write-data channel.
REQ-009 s_bresp/s_bvalid/s_bready  out/out/in  2/1/1  AXI4-Lite write-response channel.
REQ-010 s_araddr/s_arvalid/s_arready  in/in/out  32/1/1  AXI4-Lite read-address channel.
REQ-011 s_rdata/s_rresp/s_rvalid/s_rready  out/out/out/in  32/2/1/1  AXI4-Lite read-data channel.
REQ-012 m_valid  out  1  bus request valid.
REQ-013 m_ready  in  1  bus request accepted.
REQ-014 m_write  out  1  1 = write request, 0 = read request.
REQ-015 m_addr  out  ADDRESS_WIDTH  word address, equal to axi_addr[ADDRESS_WIDTH+1:2].
REQ-016 m_data  out  DATA_WIDTH  write data, equal to s_wdata[DATA_WIDTH-1:0].
REQ-017 m_id  out  MASTER_ID_WIDTH  constant MASTER_ID.
REQ-018 m_rvalid / m_rready / m_rdata  in / out / in  1 / 1 / DATA_WIDTH  bus read-response channel.

Function
REQ-019 The block SHALL run one transaction at a time through the FSM states IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_WAIT and RD_RESP.
REQ-020 In IDLE, AW and W SHALL be captured independently and in either order: s_awready=1 until AW is held, and s_wready=1 until W is held.
REQ-021 IDLE SHALL go to WR_ISSUE when both AW and W are held, and to RD_ISSUE when AR is accepted (s_arready=1 in IDLE only).
REQ-022 When a write is complete and AR is valid in the same cycle, a 1-bit last_was_read flag SHALL arbitrate: reads win if last_was_read=0, writes win otherwise; the loser stays pending.
REQ-023 WR_ISSUE SHALL hold m_valid=1 and m_write=1 with stable fields until m_ready=1, then go to WR_RESP; bus writes are posted.
REQ-024 WR_RESP SHALL hold s_bvalid=1 until s_bready=1, then clear the held AW/W and return to IDLE.
REQ-025 RD_ISSUE SHALL hold m_valid=1 and m_write=0 until m_ready=1, then go to RD_WAIT.
REQ-026 RD_WAIT SHALL drive m_rready=1, register {(32-DATA_WIDTH)'b0, m_rdata} on m_rvalid, and go to RD_RESP.
REQ-027 RD_RESP SHALL hold s_rvalid=1 and s_rresp=OKAY until s_rready=1, then return to IDLE.
REQ-028 m_rready SHALL be 0 outside RD_WAIT.
REQ-029 Minimum latency: AW+W to s_bvalid is 2 cycles with m_ready=1; AR to s_rvalid is 2 cycles plus bus read latency.
REQ-030 Address bits [1:0] and those above ADDRESS_WIDTH+1 SHALL be ignored.

Reset
REQ-031 While reset=0, the block SHALL be in IDLE with all held requests cleared, last_was_read=0, and every ready/valid output, s_bresp, s_rresp and s_rdata at 0.
REQ-032 A reset assertion mid-transaction SHALL abandon it with no response issued; ready outputs SHALL rise on the first clock edge after release.

Configuration
REQ-033 With AXIL2BUS_STRB_CHECK_EN defined, a write whose s_wstrb does not cover bits [DATA_WIDTH-1:0] SHALL skip WR_ISSUE, issue no bus request, and respond s_bresp=SLVERR (2'b10).
REQ-034 Without AXIL2BUS_STRB_CHECK_EN, s_wstrb SHALL be ignored and s_bresp SHALL always be OKAY.

Structure
REQ-035 The FSM state enum and the AXI response constants (OKAY=2'b00, SLVERR=2'b10) SHALL live in shared package axil_bus_pkg.
REQ-036 The block SHALL contain no sub-modules; it is a single FSM plus capture registers.

Verification
REQ-037 Write: AW 0x0000_0010 one cycle before W 0x00AB_CDEF (wstrb=4'hF) -> m_addr=0x4, m_data=0xABCDEF, m_write=1; then s_bvalid with OKAY.
REQ-038 Write, W before AW with m_ready held low 5 cycles -> m_valid and all fields stable for 5 cycles; exactly one bus request; one B response.
REQ-039 Read: araddr=0x8, bus returns 0x123456 after 3 cycles -> m_addr=0x2; s_rdata=0x0012_3456, OKAY; s_rready low 4 cycles -> data held.
REQ-040 AR and a complete write in the same cycle after reset -> read served first, then write; repeat -> write served first.
REQ-041 Macro defined, wstrb=4'h1 -> no m_valid, s_bresp=2'b10; macro undefined -> bus write issued, s_bresp=2'b00.
REQ-042 Reset asserted in RD_WAIT -> outputs cleared immediately; the next read after release completes normally.
